vga_sync_gen: RTL and testbench

//  640x480@60 Hz VGA timing generator, directly upstream of the VGA paint stage.

---
 rtl/vga_timing_pkg.sv | 45 ++++
 rtl/vga_axis_counter.sv | 63 ++++++
 rtl/vga_sync_gen.sv | 154 +++++++++++++++
 tb/tb_vga_sync_gen.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, counter widths, phase type and the colour-bar lookup
// used by vga_sync_gen when VGA_TEST_PATTERN_EN is defined.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned RGB_W = 24;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned H_TOTAL      = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned H_SYNC_START = DEF_H_ACTIVE + DEF_H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;

    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;
    localparam int unsigned V_TOTAL      = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int unsigned V_SYNC_START = DEF_V_ACTIVE + DEF_V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

    localparam int unsigned BAR_WIDTH = 80;

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} h_phase_e;

    function automatic logic [RGB_W-1:0] bar_colour(input logic [CNT_W-1:0] x);
        logic [CNT_W-1:0] bar;
        logic [RGB_W-1:0] colour;
        bar = x / CNT_W'(BAR_WIDTH);
        case (bar)
            CNT_W'(0): colour = 24'hFFFFFF;
            CNT_W'(1): colour = 24'hFFFF00;
            CNT_W'(2): colour = 24'h00FFFF;
            CNT_W'(3): colour = 24'h00FF00;
            CNT_W'(4): colour = 24'hFF00FF;
            CNT_W'(5): colour = 24'hFF0000;
            CNT_W'(6): colour = 24'h0000FF;
            default:   colour = 24'h000000;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus a phase FSM that tracks which
// region (active/front/sync/back) the current count lies in.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned W          = CNT_W,
    parameter int unsigned ACTIVE_LEN = DEF_H_ACTIVE,
    parameter int unsigned SYNC_START = H_SYNC_START,
    parameter int unsigned SYNC_END   = H_SYNC_END,
    parameter int unsigned TOTAL      = H_TOTAL
)(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         adv_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o,
    output h_phase_e     phase_o
);

    localparam logic [W-1:0] LAST_ACTIVE = W'(ACTIVE_LEN - 1);
    localparam logic [W-1:0] LAST_FRONT  = W'(SYNC_START - 1);
    localparam logic [W-1:0] LAST_SYNC   = W'(SYNC_END - 1);
    localparam logic [W-1:0] LAST        = W'(TOTAL - 1);

    logic [W-1:0] count_q, count_d;
    h_phase_e     phase_q, phase_d;

    assign wrap_o  = adv_i && (count_q == LAST);
    assign count_o = count_q;
    assign phase_o = phase_q;

    always_comb begin
        count_d = count_q;
        if (adv_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    // Phase moves on the same advance that carries the count across a region boundary,
    // so phase_q always describes count_q.
    always_comb begin
        phase_d = phase_q;
        if (adv_i) begin
            unique case (phase_q)
                ACTIVE: if (count_q == LAST_ACTIVE) phase_d = FRONT;
                FRONT:  if (count_q == LAST_FRONT)  phase_d = SYNC;
                SYNC:   if (count_q == LAST_SYNC)   phase_d = BACK;
                BACK:   if (count_q == LAST)        phase_d = ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            phase_q <= ACTIVE;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: 25 MHz pixel enable from Clk_50MHz, registered syncs and
// coordinates. Define VGA_TEST_PATTERN_EN to drive 8 vertical colour bars on Pattern_RGB.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK
)(
    input  logic             Clk_50MHz,
    input  logic             Reset_N,
    output logic             VGA_CLK,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK_N,
    output logic             VGA_SYNC_N,
    output logic [CNT_W-1:0] Pix_X,
    output logic [CNT_W-1:0] Pix_Y,
    output logic             Pix_Valid,
    output logic             Frame_Start,
    output logic [RGB_W-1:0] Pattern_RGB
);

    localparam int unsigned H_LEN = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_LEN = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    logic             pix_en_q, pix_en_d;
    logic             vga_clk_q, vga_clk_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             valid_q, valid_d;
    logic             fs_q, fs_d;
    logic             mid_frame_q, mid_frame_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, v_wrap;
    h_phase_e         h_phase, v_phase;

    vga_axis_counter #(
        .W          (CNT_W),
        .ACTIVE_LEN (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FRONT),
        .SYNC_END   (H_ACTIVE + H_FRONT + H_SYNC),
        .TOTAL      (H_LEN)
    ) u_h_axis (
        .clk_i   (Clk_50MHz),
        .rst_ni  (Reset_N),
        .adv_i   (pix_en_q),
        .count_o (h_cnt),
        .wrap_o  (h_wrap),
        .phase_o (h_phase)
    );

    vga_axis_counter #(
        .W          (CNT_W),
        .ACTIVE_LEN (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FRONT),
        .SYNC_END   (V_ACTIVE + V_FRONT + V_SYNC),
        .TOTAL      (V_LEN)
    ) u_v_axis (
        .clk_i   (Clk_50MHz),
        .rst_ni  (Reset_N),
        .adv_i   (h_wrap),
        .count_o (v_cnt),
        .wrap_o  (v_wrap),
        .phase_o (v_phase)
    );

    always_comb begin
        pix_en_d    = ~pix_en_q;
        vga_clk_d   = ~pix_en_q;
        x_d         = x_q;
        y_d         = y_q;
        valid_d     = valid_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        mid_frame_d = mid_frame_q;
        if (pix_en_q) begin
            x_d         = h_cnt;
            y_d         = v_cnt;
            valid_d     = (h_phase == ACTIVE) && (v_phase == ACTIVE);
            hs_d        = (h_phase != SYNC);
            vs_d        = (v_phase != SYNC);
            // Clears on the update that wraps both axes, so the following update presents (0,0).
            mid_frame_d = ~v_wrap;
        end
        fs_d = pix_en_q & ~mid_frame_q;
    end

    always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
        if (!Reset_N) begin
            pix_en_q    <= 1'b0;
            vga_clk_q   <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            valid_q     <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            fs_q        <= 1'b0;
            mid_frame_q <= 1'b0;
        end else begin
            pix_en_q    <= pix_en_d;
            vga_clk_q   <= vga_clk_d;
            x_q         <= x_d;
            y_q         <= y_d;
            valid_q     <= valid_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            fs_q        <= fs_d;
            mid_frame_q <= mid_frame_d;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [RGB_W-1:0] rgb_q, rgb_d;

    always_comb begin
        rgb_d = rgb_q;
        if (pix_en_q) begin
            rgb_d = valid_d ? bar_colour(h_cnt) : '0;
        end
    end

    always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
        if (!Reset_N) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign Pattern_RGB = rgb_q;
`else
    assign Pattern_RGB = '0;
`endif

    assign VGA_CLK     = vga_clk_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = valid_q;
    assign VGA_SYNC_N  = 1'b0;
    assign Pix_X       = x_q;
    assign Pix_Y       = y_q;
    assign Pix_Valid   = valid_q;
    assign Frame_Start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full horizontal geometry, short vertical geometry so whole frames fit.
// Expected outputs come from pixel arithmetic on the number of clocks since reset release.
module tb_vga_sync_gen;

    localparam int unsigned H_ACT = 640;
    localparam int unsigned H_FP  = 16;
    localparam int unsigned H_SW  = 96;
    localparam int unsigned H_BP  = 48;
    localparam int unsigned V_ACT = 4;
    localparam int unsigned V_FP  = 2;
    localparam int unsigned V_SW  = 2;
    localparam int unsigned V_BP  = 2;
    localparam int unsigned H_TOT = H_ACT + H_FP + H_SW + H_BP;
    localparam int unsigned V_TOT = V_ACT + V_FP + V_SW + V_BP;
    localparam int unsigned FRAME_PX = H_TOT * V_TOT;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

    typedef struct packed {
        logic        clk_o;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        valid;
        logic        fs;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, Pix_Valid, Frame_Start;
    logic [9:0]  Pix_X, Pix_Y;
    logic [23:0] Pattern_RGB;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned k = 0;

    vga_sync_gen #(
        .H_ACTIVE (H_ACT), .H_FRONT (H_FP), .H_SYNC (H_SW), .H_BACK (H_BP),
        .V_ACTIVE (V_ACT), .V_FRONT (V_FP), .V_SYNC (V_SW), .V_BACK (V_BP)
    ) dut (
        .Clk_50MHz   (clk),
        .Reset_N     (rst_n),
        .VGA_CLK     (VGA_CLK),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .Pix_X       (Pix_X),
        .Pix_Y       (Pix_Y),
        .Pix_Valid   (Pix_Valid),
        .Frame_Start (Frame_Start),
        .Pattern_RGB (Pattern_RGB)
    );

    always #10 clk = ~clk;

    // Clock edges seen since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // Every second edge shows a new pixel; the first update edge after release shows pixel 0.
    function automatic exp_t model(input int unsigned kk);
        exp_t e;
        int unsigned u, p, x, y;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        e.clk_o = (kk % 2 == 1);
        if (kk >= 2) begin
            u = kk / 2;
            p = (u - 1) % FRAME_PX;
            x = p % H_TOT;
            y = p / H_TOT;
            e.x = 10'(x);
            e.y = 10'(y);
            e.valid = (x < H_ACT) && (y < V_ACT);
            e.blank = e.valid;
            e.hs = !((x >= H_ACT + H_FP) && (x < H_ACT + H_FP + H_SW));
            e.vs = !((y >= V_ACT + V_FP) && (y < V_ACT + V_FP + V_SW));
            e.fs = (kk % 2 == 0) && (p == 0);
`ifdef VGA_TEST_PATTERN_EN
            if (e.valid) e.rgb = BARS[x / 80];
`endif
        end
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.clk_o = VGA_CLK;
        o.hs    = VGA_HS;
        o.vs    = VGA_VS;
        o.blank = VGA_BLANK_N;
        o.valid = Pix_Valid;
        o.fs    = Frame_Start;
        o.x     = Pix_X;
        o.y     = Pix_Y;
        o.rgb   = Pattern_RGB;
        return o;
    endfunction

    task automatic test_reset();
        exp_t e, o;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        e = model(0);
        o = observe();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", o, e);
        end
        n_checks++;
        if (VGA_SYNC_N !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_n: got %b expected 0", VGA_SYNC_N);
        end
    endtask

    task automatic test_first_pixel();
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({VGA_CLK, Frame_Start, Pix_Valid, VGA_HS, VGA_VS} !== 5'b10011) begin
            n_fail++;
            $display("FAIL first_edge: got clk/fs/valid/hs/vs=%b expected 10011",
                     {VGA_CLK, Frame_Start, Pix_Valid, VGA_HS, VGA_VS});
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (Pix_X !== 10'd0 || Pix_Y !== 10'd0 || Pix_Valid !== 1'b1 || VGA_BLANK_N !== 1'b1
            || Frame_Start !== 1'b1 || VGA_CLK !== 1'b0) begin
            n_fail++;
            $display("FAIL first_pixel: got (%0d,%0d) valid=%b blank=%b fs=%b vclk=%b expected (0,0) 1 1 1 0",
                     Pix_X, Pix_Y, Pix_Valid, VGA_BLANK_N, Frame_Start, VGA_CLK);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (Frame_Start !== 1'b0 || Pix_X !== 10'd0 || VGA_CLK !== 1'b1) begin
            n_fail++;
            $display("FAIL first_pixel_hold: got fs=%b x=%0d vclk=%b expected fs=0 x=0 vclk=1",
                     Frame_Start, Pix_X, VGA_CLK);
        end
    endtask

    task automatic test_frame_timing(input int unsigned ncyc);
        exp_t e, o;
        int unsigned cyc = 0;
        int unsigned hs_fall = 0, vs_fall = 0, fs_last = 0, vclk_rise = 0;
        int unsigned fs_got = 0, fs_exp = 0, vs_periods = 0;
        bit hs_seen = 0, vs_seen = 0, fs_seen = 0, vclk_seen = 0;
        logic hs_prev, vs_prev, vclk_prev;
        hs_prev = VGA_HS;
        vs_prev = VGA_VS;
        vclk_prev = VGA_CLK;
        for (int unsigned i = 0; i < ncyc; i++) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            e = model(k);
            o = observe();
            n_checks++;
            if (o.x !== e.x || o.y !== e.y) begin
                n_fail++;
                $display("FAIL scan_xy: got (%0d,%0d) expected (%0d,%0d)", o.x, o.y, e.x, e.y);
            end
            n_checks++;
            if ({o.valid, o.blank} !== {e.valid, e.blank}) begin
                n_fail++;
                $display("FAIL scan_valid_blank at (%0d,%0d): got %b expected %b",
                         e.x, e.y, {o.valid, o.blank}, {e.valid, e.blank});
            end
            n_checks++;
            if ({o.hs, o.vs} !== {e.hs, e.vs}) begin
                n_fail++;
                $display("FAIL scan_sync at (%0d,%0d): got hs/vs=%b expected %b",
                         e.x, e.y, {o.hs, o.vs}, {e.hs, e.vs});
            end
            n_checks++;
            if ({o.fs, o.clk_o} !== {e.fs, e.clk_o}) begin
                n_fail++;
                $display("FAIL scan_fs_vclk at k=%0d: got fs/vclk=%b expected %b",
                         k, {o.fs, o.clk_o}, {e.fs, e.clk_o});
            end
            n_checks++;
            if (o.rgb !== e.rgb) begin
                n_fail++;
                $display("FAIL scan_rgb at (%0d,%0d): got %h expected %h", e.x, e.y, o.rgb, e.rgb);
            end
            n_checks++;
            if (o.x >= 10'(H_TOT) || o.y >= 10'(V_TOT)) begin
                n_fail++;
                $display("FAIL range: got (%0d,%0d) required below (%0d,%0d)", o.x, o.y, H_TOT, V_TOT);
            end
            if (e.y == 10'(V_ACT - 1) && e.x == 10'(H_ACT - 1)) begin
                n_checks++;
                if (o.blank !== 1'b1) begin
                    n_fail++;
                    $display("FAIL edge_last_visible: got blank_n=%b expected 1", o.blank);
                end
            end
            if (e.y == 10'(V_ACT - 1) && e.x == 10'(H_ACT)) begin
                n_checks++;
                if (o.blank !== 1'b0) begin
                    n_fail++;
                    $display("FAIL edge_x_blank: got blank_n=%b expected 0", o.blank);
                end
            end
            if (e.y == 10'(V_ACT) && e.x == 10'd0) begin
                n_checks++;
                if (o.blank !== 1'b0) begin
                    n_fail++;
                    $display("FAIL edge_y_blank: got blank_n=%b expected 0", o.blank);
                end
            end
`ifdef VGA_TEST_PATTERN_EN
            if (e.y == 10'd0 && (e.x == 10'd0 || e.x == 10'd80 || e.x == 10'd560 || e.x == 10'd700)) begin
                n_checks++;
                if (o.rgb !== ((e.x == 10'd0)  ? 24'hFFFFFF :
                               (e.x == 10'd80) ? 24'hFFFF00 : 24'h000000)) begin
                    n_fail++;
                    $display("FAIL pattern_point x=%0d: got %h", e.x, o.rgb);
                end
            end
`endif
            if (hs_prev && !o.hs) begin
                if (hs_seen) begin
                    n_checks++;
                    if (cyc - hs_fall !== 2 * H_TOT) begin
                        n_fail++;
                        $display("FAIL hs_period: got %0d clocks expected %0d", cyc - hs_fall, 2 * H_TOT);
                    end
                end
                n_checks++;
                if (o.x !== 10'(H_ACT + H_FP)) begin
                    n_fail++;
                    $display("FAIL hs_start: got x=%0d expected %0d", o.x, H_ACT + H_FP);
                end
                hs_fall = cyc;
                hs_seen = 1;
            end
            if (!hs_prev && o.hs && hs_seen) begin
                n_checks++;
                if (cyc - hs_fall !== 2 * H_SW) begin
                    n_fail++;
                    $display("FAIL hs_width: got %0d clocks expected %0d", cyc - hs_fall, 2 * H_SW);
                end
            end
            if (vs_prev && !o.vs) begin
                if (vs_seen) begin
                    n_checks++;
                    vs_periods++;
                    if (cyc - vs_fall !== 2 * FRAME_PX) begin
                        n_fail++;
                        $display("FAIL vs_period: got %0d clocks expected %0d", cyc - vs_fall, 2 * FRAME_PX);
                    end
                end
                n_checks++;
                if (o.y !== 10'(V_ACT + V_FP) || o.x !== 10'd0) begin
                    n_fail++;
                    $display("FAIL vs_start: got (%0d,%0d) expected (0,%0d)", o.x, o.y, V_ACT + V_FP);
                end
                vs_fall = cyc;
                vs_seen = 1;
            end
            if (!vs_prev && o.vs && vs_seen) begin
                n_checks++;
                if (cyc - vs_fall !== 2 * V_SW * H_TOT) begin
                    n_fail++;
                    $display("FAIL vs_width: got %0d clocks expected %0d", cyc - vs_fall, 2 * V_SW * H_TOT);
                end
            end
            if (o.fs) begin
                fs_got++;
                if (fs_seen) begin
                    n_checks++;
                    if (cyc - fs_last !== 2 * FRAME_PX) begin
                        n_fail++;
                        $display("FAIL frame_period: got %0d clocks expected %0d", cyc - fs_last, 2 * FRAME_PX);
                    end
                end
                fs_last = cyc;
                fs_seen = 1;
            end
            if (e.fs) fs_exp++;
            if (!vclk_prev && o.clk_o) begin
                if (vclk_seen) begin
                    n_checks++;
                    if (cyc - vclk_rise !== 2) begin
                        n_fail++;
                        $display("FAIL vclk_period: got %0d clocks expected 2", cyc - vclk_rise);
                    end
                end
                vclk_rise = cyc;
                vclk_seen = 1;
            end
            hs_prev = o.hs;
            vs_prev = o.vs;
            vclk_prev = o.clk_o;
            if (n_fail > 40) break;
        end
        n_checks++;
        if (fs_got !== fs_exp) begin
            n_fail++;
            $display("FAIL frame_count: got %0d pulses expected %0d", fs_got, fs_exp);
        end
        n_checks++;
        if (vs_periods < 1) begin
            n_fail++;
            $display("FAIL vs_seen: got %0d vsync periods expected at least 1", vs_periods);
        end
        n_checks++;
        if (VGA_SYNC_N !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_n_run: got %b expected 0", VGA_SYNC_N);
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e, o;
        int unsigned run_len, hold, dly;
        bit found;
        for (int it = 0; it < 4; it++) begin
            found = 0;
            run_len = (it == 0) ? 2 * FRAME_PX + 4 : $urandom_range(40, 3000);
            for (int unsigned i = 0; i < run_len && !found; i++) begin
                @(posedge clk); @(negedge clk);
                e = model(k);
                o = observe();
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL pre_reset k=%0d: got %h expected %h", k, o, e);
                end
                if (it == 0 && e.x == 10'd320 && e.y == 10'd3 && k % 2 == 0) found = 1;
                if (n_fail > 40) break;
            end
            if (it == 0) begin
                n_checks++;
                if (!found) begin
                    n_fail++;
                    $display("FAIL reset_target: got no (320,3) within %0d clocks, required one", run_len);
                end
            end
            dly = $urandom_range(1, 8);
            hold = (it == 0) ? 5 : $urandom_range(1, 6);
            @(posedge clk);
            #(dly);
            rst_n = 1'b0;
            #1;
            e = model(0);
            o = observe();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_async it=%0d: got %h expected %h", it, o, e);
            end
            repeat (hold) begin
                @(negedge clk);
                o = observe();
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL reset_hold it=%0d: got %h expected %h", it, o, e);
                end
            end
            rst_n = 1'b1;
            for (int unsigned i = 0; i < 1700; i++) begin
                @(posedge clk); @(negedge clk);
                e = model(k);
                o = observe();
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL post_reset k=%0d: got %h expected %h", k, o, e);
                end
                if (k == 2) begin
                    n_checks++;
                    if (Pix_X !== 10'd0 || Pix_Y !== 10'd0 || Frame_Start !== 1'b1) begin
                        n_fail++;
                        $display("FAIL restart_origin: got (%0d,%0d) fs=%b expected (0,0) fs=1",
                                 Pix_X, Pix_Y, Frame_Start);
                    end
                end
                if (n_fail > 40) break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_frame_timing(4 * FRAME_PX + 400);
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
